// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding and default geometry for capture_sequencer.
// The derived widths below describe the default build (7 channels, 8-bit
// bytes, 10 bytes per channel).
package capture_pkg;

  // $clog2 that never collapses to a zero-width vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_CHANNELS = 7;
  localparam int DEF_SAMPLE_BITS  = 8;
  localparam int DEF_DEPTH        = 10;

  localparam int CH_W     = clog2_min1(DEF_NUM_CHANNELS);
  localparam int SEL_W    = clog2_min1(DEF_NUM_CHANNELS + 1);
  localparam int IDX_W    = clog2_min1(DEF_DEPTH);
  localparam int BUF_BITS = DEF_SAMPLE_BITS * DEF_DEPTH;
  localparam int CNT_W    = clog2_min1(BUF_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_LOAD,
    ST_READOUT
  } state_e;

endpackage

// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: valid/ready readout byte port of the capture sequencer.
// The sequencer drives the master side; the consumer (uo_out mux or host
// readout logic) uses the slave side.
interface capture_sequencer_if
  import capture_pkg::*;
#(
  parameter int DATA_W = DEF_SAMPLE_BITS,
  parameter int CHAN_W = CH_W
);
  logic [DATA_W-1:0] rd_data;
  logic [CHAN_W-1:0] rd_chan;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport master (
    output rd_data, rd_chan, rd_valid, rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_data, rd_chan, rd_valid, rd_last,
    output rd_ready
  );
endinterface

// File: rtl/channel_sample_buffer.sv
// channel_sample_buffer: one SAMPLE_BITS*DEPTH-bit shift register per channel
// plus a (channel, byte index) byte-select mux. The earliest captured bit ends
// up in the MSB of the register, so byte 0 is the top byte and each byte reads
// out MSB-first in capture order.
module channel_sample_buffer
  import capture_pkg::*;
#(
  parameter int  NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int  SAMPLE_BITS  = DEF_SAMPLE_BITS,
  parameter int  DEPTH        = DEF_DEPTH,
  localparam int CHAN_W       = clog2_min1(NUM_CHANNELS),
  localparam int BYTE_IDX_W   = clog2_min1(DEPTH),
  localparam int BUF_LEN      = SAMPLE_BITS * DEPTH
) (
  input  logic                    clk,
  input  logic                    shift_en_i,
  input  logic [NUM_CHANNELS-1:0] sample_i,
  input  logic [CHAN_W-1:0]       sel_chan_i,
  input  logic [BYTE_IDX_W-1:0]   sel_idx_i,
  output logic [SAMPLE_BITS-1:0]  byte_o
);

  logic [BUF_LEN-1:0] shreg_q [NUM_CHANNELS];
  logic [BUF_LEN-1:0] chan_vec;

  // Shift each channel's new sample into bit 0 while capture is enabled.
  // NOTE: sample storage has no reset; its contents are only meaningful after
  // a full capture, so clearing it would just cost reset fan-out.
  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shreg_q[c] <= {shreg_q[c][BUF_LEN-2:0], sample_i[c]};
      end
    end
  end

  // Select a channel, then one byte of it; byte 0 occupies the top bits.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can infer a latch.
  always_comb begin
    chan_vec = '0;
    byte_o   = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (sel_chan_i == CHAN_W'(c)) chan_vec = shreg_q[c];
    end
    for (int b = 0; b < DEPTH; b++) begin
      if (sel_idx_i == BYTE_IDX_W'(b)) byte_o = chan_vec[BUF_LEN-1-SAMPLE_BITS*b -: SAMPLE_BITS];
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: arms on request, waits for a channel rising edge or an
// external trigger, captures DEPTH bytes per channel and drains them one
// channel at a time through a registered valid/ready byte port.
// Optional feature: define CAPTURE_CHAN_MASK_EN to add the chan_mask input,
// which excludes channels from readout (mask sampled once, in LOAD).
module capture_sequencer
  import capture_pkg::*;
#(
  parameter int  NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int  SAMPLE_BITS  = DEF_SAMPLE_BITS,
  parameter int  DEPTH        = DEF_DEPTH,
  localparam int CHAN_W       = clog2_min1(NUM_CHANNELS),
  localparam int TSEL_W       = clog2_min1(NUM_CHANNELS + 1),
  localparam int BYTE_IDX_W   = clog2_min1(DEPTH),
  localparam int BUF_LEN      = SAMPLE_BITS * DEPTH,
  localparam int SHIFT_CNT_W  = clog2_min1(BUF_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] sample_in,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    trig_ext,
  input  logic [TSEL_W-1:0]       trig_sel,
`ifdef CAPTURE_CHAN_MASK_EN
  input  logic [NUM_CHANNELS-1:0] chan_mask,
`endif
  capture_sequencer_if.master     rd,
  output logic                    busy,
  output logic                    done
);

  localparam logic [BYTE_IDX_W-1:0]  IDX_LAST = BYTE_IDX_W'(DEPTH - 1);
  localparam logic [SHIFT_CNT_W-1:0] CNT_FULL = SHIFT_CNT_W'(BUF_LEN);

  state_e                   state_q, state_d;
  logic [NUM_CHANNELS-1:0]  prev_q;
  logic [SHIFT_CNT_W-1:0]   cap_cnt_q, cap_cnt_d;
  logic [BYTE_IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic [CHAN_W-1:0]        rd_chan_q, rd_chan_d;
  logic [SAMPLE_BITS-1:0]   rd_data_q, rd_data_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     rd_last_q, rd_last_d;
  logic                     done_q, done_d;
  logic [NUM_CHANNELS-1:0]  mask_q, mask_d;

  logic [NUM_CHANNELS-1:0]  mask_now;
  logic [NUM_CHANNELS-1:0]  mask_sel;
  logic                     trig_fire;
  logic                     shift_en;
  logic                     xfer;
  logic [CHAN_W-1:0]        addr_chan;
  logic [BYTE_IDX_W-1:0]    addr_idx;
  logic                     addr_last;
  logic [SAMPLE_BITS-1:0]   sel_byte;

`ifdef CAPTURE_CHAN_MASK_EN
  assign mask_now = chan_mask;
`else
  assign mask_now = '1;
`endif

  // Lowest channel whose mask bit is set (0 when the mask is empty).
  function automatic logic [CHAN_W-1:0] first_chan(input logic [NUM_CHANNELS-1:0] m);
    first_chan = '0;
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (m[c]) first_chan = CHAN_W'(c);
    end
  endfunction

  // Highest channel whose mask bit is set.
  function automatic logic [CHAN_W-1:0] last_chan(input logic [NUM_CHANNELS-1:0] m);
    last_chan = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (m[c]) last_chan = CHAN_W'(c);
    end
  endfunction

  // Next included channel strictly above cur.
  function automatic logic [CHAN_W-1:0] next_chan(input logic [CHAN_W-1:0]       cur,
                                                  input logic [NUM_CHANNELS-1:0] m);
    logic found;
    next_chan = cur;
    found     = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!found && m[c] && (CHAN_W'(c) > cur)) begin
        next_chan = CHAN_W'(c);
        found     = 1'b1;
      end
    end
  endfunction

  channel_sample_buffer #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .SAMPLE_BITS  (SAMPLE_BITS),
    .DEPTH        (DEPTH)
  ) u_buffer (
    .clk        (clk),
    .shift_en_i (shift_en),
    .sample_i   (sample_in),
    .sel_chan_i (addr_chan),
    .sel_idx_i  (addr_idx),
    .byte_o     (sel_byte)
  );

  // Trigger: rising edge on the selected channel, or trig_ext when the
  // selector points one past the last channel.
  always_comb begin
    trig_fire = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (trig_sel == TSEL_W'(c)) trig_fire = sample_in[c] & ~prev_q[c];
    end
    if (trig_sel == TSEL_W'(NUM_CHANNELS)) trig_fire = trig_ext;
  end

  assign xfer = rd_valid_q & rd.rd_ready;

  // Address of the byte to register next: first byte in LOAD, otherwise the
  // successor of the byte currently presented.
  always_comb begin
    mask_sel = (state_q == ST_LOAD) ? mask_now : mask_q;
    if (state_q == ST_LOAD) begin
      addr_chan = first_chan(mask_sel);
      addr_idx  = '0;
    end else if (rd_idx_q == IDX_LAST) begin
      addr_chan = next_chan(rd_chan_q, mask_sel);
      addr_idx  = '0;
    end else begin
      addr_chan = rd_chan_q;
      addr_idx  = rd_idx_q + BYTE_IDX_W'(1);
    end
    addr_last = (addr_idx == IDX_LAST) && (addr_chan == last_chan(mask_sel));
  end

  // Next-state and datapath update; abort overrides whatever the state chose.
  always_comb begin
    state_d    = state_q;
    cap_cnt_d  = cap_cnt_q;
    rd_idx_d   = rd_idx_q;
    rd_chan_d  = rd_chan_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    mask_d     = mask_q;
    done_d     = 1'b0;
    shift_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d   = ST_ARMED;
          cap_cnt_d = '0;
        end
      end

      ST_ARMED: begin
        // The trigger cycle's sample is capture bit 1.
        if (trig_fire) begin
          shift_en  = 1'b1;
          cap_cnt_d = SHIFT_CNT_W'(1);
          state_d   = (cap_cnt_d == CNT_FULL) ? ST_LOAD : ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        shift_en  = 1'b1;
        cap_cnt_d = cap_cnt_q + SHIFT_CNT_W'(1);
        if (cap_cnt_d == CNT_FULL) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        mask_d = mask_now;
        if (mask_now == '0) begin
          // Nothing to read: finish immediately.
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          rd_chan_d  = addr_chan;
          rd_idx_d   = addr_idx;
          rd_data_d  = sel_byte;
          rd_last_d  = addr_last;
          rd_valid_d = 1'b1;
          state_d    = ST_READOUT;
        end
      end

      ST_READOUT: begin
        if (xfer) begin
          if (rd_last_q) begin
            state_d    = ST_IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            done_d     = 1'b1;
          end else begin
            // Reload on the transfer edge so transfers can run back-to-back.
            rd_chan_d = addr_chan;
            rd_idx_d  = addr_idx;
            rd_data_d = sel_byte;
            rd_last_d = addr_last;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d    = ST_IDLE;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      done_d     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Counters, edge-detect history and registered readout port.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      cap_cnt_q  <= '0;
      rd_idx_q   <= '0;
      rd_chan_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      mask_q     <= '0;
    end else begin
      prev_q     <= sample_in;
      cap_cnt_q  <= cap_cnt_d;
      rd_idx_q   <= rd_idx_d;
      rd_chan_q  <= rd_chan_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
      mask_q     <= mask_d;
    end
  end

  assign rd.rd_data  = rd_data_q;
  assign rd.rd_chan  = rd_chan_q;
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_last  = rd_last_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed bench for capture_sequencer. Each channel is
// driven with a known byte sequence; readout is checked cycle by cycle against
// a table of expected port values built from that sequence.
`timescale 1ns/1ps
module tb_capture_sequencer;
  import capture_pkg::*;

  localparam int NC     = DEF_NUM_CHANNELS;
  localparam int SB     = DEF_SAMPLE_BITS;
  localparam int DP     = DEF_DEPTH;
  localparam int BUF    = SB * DP;
  localparam int SC_PAT = 0;
  localparam int SC_EXT = 1;

  typedef struct {
    logic          ready;
    logic          arm;
    logic          exp_valid;
    logic          exp_busy;
    logic          exp_done;
    logic          exp_last;
    logic [7:0]    exp_data;
    logic [CH_W-1:0] exp_chan;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   sample_in;
  logic            arm;
  logic            abort;
  logic            trig_ext;
  logic [SEL_W-1:0] trig_sel;
`ifdef CAPTURE_CHAN_MASK_EN
  logic [NC-1:0]   chan_mask;
`endif
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_fail   = 0;
  logic rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  capture_sequencer_if rd_if ();

  capture_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .sample_in (sample_in),
    .arm       (arm),
    .abort     (abort),
    .trig_ext  (trig_ext),
    .trig_sel  (trig_sel),
`ifdef CAPTURE_CHAN_MASK_EN
    .chan_mask (chan_mask),
`endif
    .rd        (rd_if),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Byte b of channel ch as driven onto the sample pins.
  function automatic logic [7:0] exp_byte(input int scen, input int ch, input int b);
    logic [7:0] v;
    if (scen == SC_EXT) begin
      v = (ch == 3) ? 8'hFF : 8'h00;
    end else begin
      case (ch)
        0:       v = 8'hA5;
        1:       v = 8'(b);
        2:       v = 8'hFF;
        3:       v = 8'h3C ^ 8'(b);
        4:       v = {4'(b), ~4'(b)};
        5:       v = 8'h5A;
        default: v = 8'(b * 23 + 1);
      endcase
    end
    return v;
  endfunction

  // Sample pins for capture bit k (k = 0 is the trigger cycle), MSB first.
  function automatic logic [NC-1:0] cap_bits(input int scen, input int k);
    logic [7:0] v;
    cap_bits = '0;
    for (int c = 0; c < NC; c++) begin
      v = exp_byte(scen, c, k / SB);
      cap_bits[c] = v[SB - 1 - (k % SB)];
    end
  endfunction

  // Arm, show a decoy edge on an unselected channel, then drive the capture.
  // abort_at >= 0 asserts abort during capture cycle T+abort_at and returns.
  task automatic do_capture(input int scen, input int abort_at, input bit rearm);
    logic early;
    early = 1'b0;
    @(negedge clk);
    trig_sel = (scen == SC_EXT) ? SEL_W'(NC) : SEL_W'(2);
    sample_in = (scen == SC_EXT) ? NC'(7'b0001000) : '0;
    rd_if.rd_ready = 1'b0;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("busy_after_arm", busy, 1);
    sample_in = (scen == SC_EXT) ? NC'(7'b0001101) : NC'(7'b0000001);
    @(negedge clk);
    for (int k = 0; k < BUF; k++) begin
      sample_in = cap_bits(scen, k);
      trig_ext  = (scen == SC_EXT) && (k == 0);
      arm       = rearm && (k == 20);
      abort     = (k == abort_at);
      @(negedge clk);
      early |= rd_if.rd_valid | done;
      if (k == abort_at) begin
        abort = 1'b0;
        return;
      end
    end
    trig_ext = 1'b0;
    arm      = 1'b0;
    check("valid_or_done_during_capture", early, 0);
    check("load_cycle_valid_low", rd_if.rd_valid, 0);
    check("load_cycle_busy", busy, 1);
  endtask

  // Build the expected readout table, then apply it one cycle per entry.
  task automatic do_readout(input int scen, input bit bp, input logic [NC-1:0] mask, input bit rearm);
    vec_t vecs[$];
    vec_t v;
    int   chans[$];
    int   n, cyc, total;
    for (int c = 0; c < NC; c++) if (mask[c]) chans.push_back(c);
    total = chans.size() * DP;
    n = 0;
    cyc = 0;
    while (n < total) begin
      v.ready     = bp ? rdy_pat[cyc % 4] : 1'b1;
      v.arm       = rearm && (cyc == 5);
      v.exp_valid = 1'b1;
      v.exp_busy  = 1'b1;
      v.exp_done  = 1'b0;
      v.exp_last  = (n == total - 1);
      v.exp_chan  = CH_W'(chans[n / DP]);
      v.exp_data  = exp_byte(scen, chans[n / DP], n % DP);
      vecs.push_back(v);
      if (v.ready) n++;
      cyc++;
    end
    v.ready = 1'b0; v.arm = 1'b0; v.exp_valid = 1'b0; v.exp_busy = 1'b0;
    v.exp_done = 1'b1; v.exp_last = 1'b0; v.exp_chan = '0; v.exp_data = '0;
    vecs.push_back(v);
    v.exp_done = 1'b0;
    vecs.push_back(v);

    foreach (vecs[i]) begin
      @(negedge clk);
      check($sformatf("rd_valid[%0d]", i), rd_if.rd_valid, vecs[i].exp_valid);
      check($sformatf("busy[%0d]", i), busy, vecs[i].exp_busy);
      check($sformatf("done[%0d]", i), done, vecs[i].exp_done);
      check($sformatf("rd_last[%0d]", i), rd_if.rd_last, vecs[i].exp_last);
      if (vecs[i].exp_valid) begin
        check($sformatf("rd_data[%0d]", i), rd_if.rd_data, vecs[i].exp_data);
        check($sformatf("rd_chan[%0d]", i), rd_if.rd_chan, vecs[i].exp_chan);
      end
      rd_if.rd_ready = vecs[i].ready;
      arm            = vecs[i].arm;
    end
    rd_if.rd_ready = 1'b0;
    arm            = 1'b0;
  endtask

  task automatic run_full(input int scen, input bit bp, input logic [NC-1:0] mask, input bit rearm);
`ifdef CAPTURE_CHAN_MASK_EN
    chan_mask = mask;
`endif
    do_capture(scen, -1, rearm);
    do_readout(scen, bp, mask, rearm);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; arm = 1'b0; abort = 1'b0; trig_ext = 1'b0;
    trig_sel = '0; sample_in = '0; rd_if.rd_ready = 1'b0;
`ifdef CAPTURE_CHAN_MASK_EN
    chan_mask = '1;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", rd_if.rd_valid, 0);
    check("reset_last", rd_if.rd_last, 0);
    check("reset_data", rd_if.rd_data, 0);
    check("reset_chan", rd_if.rd_chan, 0);
    reset = 1'b0;

    // Channel trigger, full-speed readout.
    run_full(SC_PAT, 1'b0, '1, 1'b0);
    // External trigger.
    run_full(SC_EXT, 1'b0, '1, 1'b0);
    // Backpressure 1,0,0,1.
    run_full(SC_PAT, 1'b1, '1, 1'b0);

    // Abort at T+40, then a normal run.
    do_capture(SC_PAT, 40, 1'b0);
    check("abort_busy", busy, 0);
    check("abort_valid", rd_if.rd_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seen |= rd_if.rd_valid | done | busy;
    end
    check("abort_quiet", seen, 0);
    run_full(SC_PAT, 1'b0, '1, 1'b0);

    // arm pulses in CAPTURE and READOUT must not disturb the run.
    run_full(SC_PAT, 1'b1, '1, 1'b1);

    // arm together with abort in IDLE.
    @(negedge clk);
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    check("arm_abort_idle_busy", busy, 0);
    @(negedge clk);
    check("arm_abort_idle_busy_later", busy, 0);

`ifdef CAPTURE_CHAN_MASK_EN
    run_full(SC_PAT, 1'b0, NC'(7'b0000101), 1'b0);
    run_full(SC_PAT, 1'b0, '0, 1'b0);
`endif

    // Reset in the middle of readout acts like abort and restores reset values.
    do_capture(SC_PAT, -1, 1'b0);
    @(negedge clk);
    check("pre_reset_valid", rd_if.rd_valid, 1);
    rd_if.rd_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd_if.rd_ready = 1'b0;
    check("midreset_busy", busy, 0);
    check("midreset_valid", rd_if.rd_valid, 0);
    check("midreset_data", rd_if.rd_data, 0);
    check("midreset_chan", rd_if.rd_chan, 0);
    check("midreset_done", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Control block for the per-channel sample shift buffers on the `uio_in` pins. It arms on request and waits for a trigger, either a rising edge on a selected channel or an external pulse. It then captures exactly `DEPTH` bytes per channel and drains the captured bytes one channel at a time through a valid/ready byte port toward `uo_out` or the host readout logic.

## Interface
Parameters:
- `NUM_CHANNELS`, 7: number of sampled channels.
- `SAMPLE_BITS`, 8: bits per readout byte.
- `DEPTH`, 10: bytes captured per channel; buffer length is `SAMPLE_BITS*DEPTH` bits.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sample_in`  in  `NUM_CHANNELS`: raw channel bits, one sample per clock.
- `arm`  in  1: start request; honoured only in IDLE.
- `abort`  in  1: return to IDLE from any state; wins over every other input.
- `trig_ext`  in  1: external trigger, level-sampled in ARMED.
- `trig_sel`  in  `$clog2(NUM_CHANNELS+1)`: values 0..NUM_CHANNELS-1 select a channel rising edge; value NUM_CHANNELS selects `trig_ext`.
- `chan_mask`  in  `NUM_CHANNELS`: 1 = include the channel in readout. Present only with `CAPTURE_CHAN_MASK_EN`.
- `rd_data`  out  `SAMPLE_BITS`: readout byte (registered).
- `rd_chan`  out  `$clog2(NUM_CHANNELS)`: channel of `rd_data`.
- `rd_valid`  out  1: byte available.
- `rd_ready`  in  1: consumer accepts.
- `rd_last`  out  1: final byte of the final channel.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse after the final byte transfers.

## Operation
- States: IDLE, ARMED, CAPTURE, LOAD, READOUT.
- IDLE -> ARMED on `arm`.
- ARMED: `prev` is a register holding last cycle's `sample_in`. The trigger fires when `sample_in[trig_sel] & ~prev[trig_sel]`, or when `trig_ext` is high and `trig_sel` == NUM_CHANNELS. On the trigger cycle the state moves to CAPTURE and the trigger cycle's sample is shifted in as capture bit 1.
- CAPTURE: every channel shifts its `sample_in` bit in each cycle. `cap_cnt` (width `$clog2(SAMPLE_BITS*DEPTH+1)`) counts shifts including the trigger cycle. After shift number `SAMPLE_BITS*DEPTH` the state moves to LOAD. Buffers shift only on the trigger cycle and in CAPTURE.
- Byte order: byte 0 is the earliest captured byte. The first captured bit of a byte is its MSB.
- LOAD: registers the first byte (lowest included channel, byte 0), sets `rd_valid`, and moves to READOUT.
- READOUT:
  - A transfer occurs when `rd_valid & rd_ready`.
  - On each transfer the next byte loads on the same edge, so back-to-back transfers are allowed: byte index increments, and on index `DEPTH-1` it wraps to 0 and advances to the next included channel in ascending order.
  - `rd_data`, `rd_chan` and `rd_last` hold stable while `rd_valid & ~rd_ready`.
  - The transfer with `rd_last` moves the state to IDLE, drops `rd_valid` and pulses `done`.
- Abort: state goes to IDLE next cycle, `rd_valid` drops, no `done` pulse. Buffer contents are undefined afterwards.
- `arm` outside IDLE is ignored. `arm` together with `abort` in the same cycle leaves the block in IDLE.
- Reset mid-operation behaves like abort. Reset values: state IDLE, `rd_valid`/`rd_last`/`busy`/`done` = 0, `rd_data` = 0, `rd_chan` = 0, counters = 0, `prev` = 0. Buffer storage is not reset.

## Timing
- Trigger at cycle T: capture covers cycles T..T+SAMPLE_BITS*DEPTH-1, LOAD is at T+80 (defaults), and `rd_valid` first goes high at T+81.
- Readout with `rd_ready` held high: one byte per cycle, 70 cycles for 7 channels, with `done` one cycle after the last transfer.
- `busy` is high from the cycle after `arm` through the cycle of the last transfer.

## Configuration
- `CAPTURE_CHAN_MASK_EN` defined: the `chan_mask` port exists and LOAD/READOUT skip channels whose mask bit is 0. With an all-zero mask, LOAD goes directly to IDLE and pulses `done` with no transfers. The mask is sampled once, in LOAD.
- Undefined: no `chan_mask` port; all channels are read.

## Structure
- Shared package `capture_pkg` holds the state enum and the derived width constants `CH_W`, `IDX_W`, `CNT_W` and `BUF_BITS`.
- Sub-module `channel_sample_buffer` contains the per-channel shift registers and a byte-select mux addressed by (channel, index). It has a shift enable and no reset.
- The controller FSM, counters, edge detect and handshake logic stay in `capture_sequencer`.

## Test plan
- Channel trigger: `trig_sel`=2; ch2 held 0 then goes 1 at T; ch0 drives pattern 0xA5 repeating MSB-first from T. Required: `rd_valid` rises at T+81, first byte `rd_chan`=0 with `rd_data`=0xA5, `rd_last` on byte 70, `done` one cycle later.
- External trigger: `trig_sel`=7, `trig_ext` pulsed with ch3 constant 1. Required: all ch3 bytes read 0xFF, all other constant-0 channels read 0x00.
- Backpressure: `rd_ready` toggles 1,0,0,1. Required: `rd_data` is stable during stalls, no byte is lost or duplicated, and 70 transfers complete in total.
- Abort during CAPTURE at T+40. Required: IDLE next cycle, `busy`=0, no `rd_valid`, no `done`; a subsequent `arm` works normally.
- Mask (macro on): `chan_mask`=7'b0000101. Required: only channels 0 and 2 are read, 20 transfers, `rd_last` on channel 2 byte 9. With `chan_mask`=0, `done` pulses with no `rd_valid`.
- Re-arm ignored: `arm` pulsed in CAPTURE and READOUT. Required: the sequence is unchanged; `arm`+`abort` together in IDLE leaves `busy`=0.
